// File: rtl/aes256_concat_if.sv
// rtl/aes256_concat_if.sv - standard_stream_if: valid/ready data stream link used by aes256_concat
interface standard_stream_if #(
    parameter int WIDTH = 512
) ();
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/aes256_concat.sv
// rtl/aes256_concat.sv - iterative AES-256 encryptor, one round per cycle, key||pt in, ct out
// Optional build macro AES_CONCAT_ECHO_EN places the input key and plaintext above the ciphertext.
module aes256_concat (
    input  logic                clk,
    input  logic                rst_n,
    standard_stream_if.slave    s0,
    standard_stream_if.master   s_out
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, next_state;
    logic [3:0]   round;
    logic [127:0] st, ka, kb, out_ct;
    logic         ready_q, valid_q, ready_d, valid_d;
    logic         accept;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = c;
        return {xt(a3) ^ xt(a0) ^ a0 ^ a1 ^ a2,
                xt(a2) ^ xt(a3) ^ a3 ^ a0 ^ a1,
                xt(a1) ^ xt(a2) ^ a2 ^ a3 ^ a0,
                xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
    endfunction

    // Byte b of every 128-bit vector sits at [8b+:8]: row b%4, column b/4.
    logic [127:0] sb, sr, mc, rnd_out;
    for (genvar b = 0; b < 16; b++) begin : g_sub
        assign sb[8*b +: 8] = SBOX[st[8*b +: 8]];
    end
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
        end
    end
    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[32*c +: 32] = mix(sr[32*c +: 32]);
    end
    assign rnd_out = ((round == 4'd14) ? sr : mc) ^ kb;

    // ka/kb hold the previous and current round keys; the next key derives from both.
    logic [31:0]  sw, tw;
    logic [3:0]   rnd_m1;
    logic [7:0]   rcon;
    logic [127:0] key_next;
    assign rnd_m1 = round - 4'd1;
    assign rcon   = 8'h01 << rnd_m1[3:1];
    assign sw     = {SBOX[kb[127:120]], SBOX[kb[119:112]], SBOX[kb[111:104]], SBOX[kb[103:96]]};
    assign tw     = round[0] ? ({sw[7:0], sw[31:8]} ^ {24'd0, rcon}) : sw;
    assign key_next[31:0]   = ka[31:0]   ^ tw;
    assign key_next[63:32]  = ka[63:32]  ^ key_next[31:0];
    assign key_next[95:64]  = ka[95:64]  ^ key_next[63:32];
    assign key_next[127:96] = ka[127:96] ^ key_next[95:64];

    assign accept = (state == IDLE) && s0.tvalid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (round == 4'd14) next_state = DONE;
            DONE:    if (valid_q && s_out.tready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready_d = (next_state == IDLE);
        valid_d = (next_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            round   <= 4'd0;
            st      <= '0;
            ka      <= '0;
            kb      <= '0;
            out_ct  <= '0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
            if (accept) begin
                ka    <= s0.tdata[127:0];
                kb    <= s0.tdata[255:128];
                st    <= s0.tdata[383:256] ^ s0.tdata[127:0];
                round <= 4'd1;
            end else if (state == RUN) begin
                st    <= rnd_out;
                ka    <= kb;
                kb    <= key_next;
                round <= round + 4'd1;
                if (round == 4'd14) begin
                    out_ct <= rnd_out;
                    round  <= 4'd0;
                end
            end
        end
    end

    logic unused_hi;
    assign unused_hi = ^s0.tdata[511:384];

    assign s0.tready    = ready_q;
    assign s_out.tvalid = valid_q;

`ifdef AES_CONCAT_ECHO_EN
    logic [383:0] echo_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      echo_q <= '0;
        else if (accept) echo_q <= {s0.tdata[255:0], s0.tdata[383:256]};
    end
    assign s_out.tdata = {echo_q, out_ct};
`else
    assign s_out.tdata = {384'd0, out_ct};
`endif
endmodule

// File: tb/tb_aes256_concat.sv
// tb/tb_aes256_concat.sv - directed FIPS-197 vectors, latency, backpressure and reset checks
module tb_aes256_concat;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    standard_stream_if #(512) s0_if ();
    standard_stream_if #(512) out_if ();

    aes256_concat dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s0    (s0_if),
        .s_out (out_if)
    );

    int checks = 0;
    int errors = 0;
    logic [127:0] junk_hi = {4{32'hdeadbeef}};

    function automatic logic [127:0] le128(input logic [127:0] f);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = f[127-8*b -: 8];
        return r;
    endfunction

    function automatic logic [255:0] le256(input logic [255:0] f);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) r[8*b +: 8] = f[255-8*b -: 8];
        return r;
    endfunction

    function automatic logic [511:0] beat(input logic [255:0] k, input logic [127:0] p,
                                          input logic [127:0] c);
`ifdef AES_CONCAT_ECHO_EN
        return {k, p, c};
`else
        return {384'd0, c};
`endif
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [255:0] k, input logic [127:0] p);
        int n = 0;
        while (!s0_if.tready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 512'(s0_if.tready), 512'd1);
        s0_if.tdata  = {junk_hi, p, k};
        s0_if.tvalid = 1'b1;
        @(negedge clk);
        s0_if.tvalid = 1'b0;
        chk({tag, "_busy"}, 512'(s0_if.tready), 512'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_if.tvalid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 512'(n), 512'd14);
    endtask

    task automatic drain(input string tag, input logic [511:0] exp);
        chk({tag, "_data"}, out_if.tdata, exp);
        out_if.tready = 1'b1;
        @(negedge clk);
        out_if.tready = 1'b0;
        chk({tag, "_valid_clr"}, 512'(out_if.tvalid), 512'd0);
        chk({tag, "_ready_back"}, 512'(s0_if.tready), 512'd1);
    endtask

    task automatic block(input string tag, input logic [255:0] kf, input logic [127:0] pf,
                         input logic [127:0] cf);
        send(tag, le256(kf), le128(pf));
        wait_valid(tag);
        drain(tag, beat(le256(kf), le128(pf), le128(cf)));
    endtask

    localparam logic [255:0] KSEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        logic saw;
        s0_if.tvalid  = 1'b0;
        s0_if.tdata   = '0;
        out_if.tready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 512'(s0_if.tready), 512'd0);
        chk("rst_out_valid", 512'(out_if.tvalid), 512'd0);
        chk("rst_out_data", out_if.tdata, 512'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 512'(s0_if.tready), 512'd1);

        block("c3", KSEQ, 128'h00112233445566778899aabbccddeeff,
              128'h8ea2b7ca516745bfeafc49904b496089);
        block("v2", KSEQ, 128'h6bc1bee22e409f96e93d7e117393172a,
              128'he0a8f50ec76a04d5a96a175aa870ef63);
        block("v3", KSEQ, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
              128'h542ddea4d5faad623ef884cf4e198bdc);
        block("kff", {256{1'b1}}, 128'd0, 128'h4bf85f1b5d54adbc307b0a048389adcb);
        block("pff", 256'd0, {128{1'b1}}, 128'hacdace8078a32b1a182bfa4987ca1347);

        send("bp", le256(KSEQ), le128(128'h00112233445566778899aabbccddeeff));
        s0_if.tdata  = {4{128'h0123456789abcdeffedcba9876543210}};
        s0_if.tvalid = 1'b1;
        wait_valid("bp");
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_if.tvalid !== 1'b1 || s0_if.tready !== 1'b0 ||
                out_if.tdata !== beat(le256(KSEQ), le128(128'h00112233445566778899aabbccddeeff),
                                      le128(128'h8ea2b7ca516745bfeafc49904b496089)))
                saw = 1'b1;
        end
        chk("bp_hold_stable", 512'(saw), 512'd0);
        s0_if.tvalid = 1'b0;
        drain("bp", beat(le256(KSEQ), le128(128'h00112233445566778899aabbccddeeff),
                         le128(128'h8ea2b7ca516745bfeafc49904b496089)));

        send("mid", le256(256'd0), le128(128'd0));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 512'(out_if.tvalid), 512'd0);
        chk("mid_rst_ready", 512'(s0_if.tready), 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_if.tvalid !== 1'b0) saw = 1'b1;
        end
        chk("mid_no_output", 512'(saw), 512'd0);
        block("post_rst", KSEQ, 128'h00112233445566778899aabbccddeeff,
              128'h8ea2b7ca516745bfeafc49904b496089);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
